// File: rtl/pkt_slot_buffer_if.sv
// Write/read handshake bundle for the packet slot buffer.
// master = producer/consumer side, slave = buffer side.
interface pkt_slot_buffer_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned SLOTS  = 16
);
   localparam int unsigned KEEP_W = DATA_W / 8;
   localparam int unsigned ID_W   = $clog2(SLOTS);

   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic [KEEP_W-1:0] wr_keep;
   logic              wr_last;
   logic [ID_W-1:0]   wr_id;
   logic              wr_done;
   logic [ID_W-1:0]   wr_done_id;
   logic              wr_ovf;
   logic              rd_req;
   logic [ID_W-1:0]   rd_id;
   logic              rd_busy;
   logic              rd_err;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic [KEEP_W-1:0] rd_keep;
   logic              rd_last;
   logic [ID_W:0]     occ_count;

   modport master (
      output wr_valid, wr_data, wr_keep, wr_last, rd_req, rd_id,
      input  wr_ready, wr_id, wr_done, wr_done_id, wr_ovf,
             rd_busy, rd_err, rd_valid, rd_data, rd_keep, rd_last, occ_count
   );

   modport slave (
      input  wr_valid, wr_data, wr_keep, wr_last, rd_req, rd_id,
      output wr_ready, wr_id, wr_done, wr_done_id, wr_ovf,
             rd_busy, rd_err, rd_valid, rd_data, rd_keep, rd_last, occ_count
   );
endinterface

// File: rtl/pkt_slot_buffer.sv
// Packet slot buffer: stores whole packets into fixed-size RAM slots in
// circular order and replays a stored packet by slot ID, releasing the slot.
module pkt_slot_buffer #(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned SLOTS      = 16,
   parameter int unsigned SLOT_BEATS = 32
) (
   input  logic             CLK,
   input  logic             reset,
   pkt_slot_buffer_if.slave bus
);
   localparam int unsigned KEEP_W = DATA_W / 8;
   localparam int unsigned ID_W   = $clog2(SLOTS);
   localparam int unsigned BA_W   = $clog2(SLOT_BEATS);
   localparam int unsigned BEAT_W = BA_W + 1;

   typedef enum logic {RD_IDLE, RD_READ} rd_state_t;

   logic [DATA_W-1:0] mem [SLOTS*SLOT_BEATS];
   logic [DATA_W-1:0] ram_q;
   logic [SLOTS-1:0]  slot_valid;
   logic [BEAT_W-1:0] slot_len  [SLOTS];
   logic [KEEP_W-1:0] slot_keep [SLOTS];

   logic [ID_W-1:0]   wr_ptr;
   logic [BEAT_W-1:0] wr_beat;
   logic              pkt_ovf;
   logic              wr_ready_c, wr_accept, wr_store, wr_commit, wr_trunc;
   logic [BEAT_W-1:0] wr_len;
   logic              done_q, ovf_q;
   logic [ID_W-1:0]   done_id_q;
   logic [ID_W:0]     occ_q;

   rd_state_t         rd_state, rd_next;
   logic [ID_W-1:0]   rd_id_q;
   logic [BEAT_W-1:0] rd_cnt, rd_last_addr;
   logic              rd_idle_ok, rd_accept, rd_reject, rd_issue, rd_issue_last, rd_release;
   logic              rd_valid_q, rd_last_q, rd_err_q;
   logic [KEEP_W-1:0] rd_keep_q;

   // Write-side decode; wr_beat != 0 means a packet is in progress, so its slot is ours.
   always_comb begin
      wr_ready_c = (wr_beat != '0) | ~slot_valid[wr_ptr];
      wr_accept  = bus.wr_valid & wr_ready_c;
      wr_store   = wr_accept & (wr_beat < BEAT_W'(SLOT_BEATS));
      wr_commit  = wr_accept & bus.wr_last;
      wr_trunc   = pkt_ovf | ~wr_store;
      wr_len     = wr_store ? wr_beat + BEAT_W'(1) : wr_beat;
   end

   // Write pointer and beat counter; beat saturates at SLOT_BEATS once beats start dropping.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         wr_beat <= '0;
         pkt_ovf <= 1'b0;
      end else if (wr_accept) begin
         if (bus.wr_last) begin
            wr_ptr  <= wr_ptr + ID_W'(1);
            wr_beat <= '0;
            pkt_ovf <= 1'b0;
         end else if (wr_store) begin
            wr_beat <= wr_beat + BEAT_W'(1);
         end else begin
            pkt_ovf <= 1'b1;
         end
      end
   end

   // Per-slot length/keep captured on commit; truncated packets replay with full keep.
   always_ff @(posedge CLK) begin
      if (wr_commit) begin
         slot_len[wr_ptr]  <= wr_len;
         slot_keep[wr_ptr] <= wr_trunc ? '1 : bus.wr_keep;
      end
   end

   // Occupancy: release and commit always target different slots, so both apply.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         slot_valid <= '0;
         occ_q      <= '0;
      end else begin
         if (rd_release) slot_valid[rd_id_q] <= 1'b0;
         if (wr_commit)  slot_valid[wr_ptr]  <= 1'b1;
         case ({wr_commit, rd_release})
            2'b10:   occ_q <= occ_q + (ID_W+1)'(1);
            2'b01:   occ_q <= occ_q - (ID_W+1)'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   // Registered write completion pulses.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         done_id_q <= '0;
      end else begin
         done_q <= wr_commit;
         ovf_q  <= wr_commit & wr_trunc;
         if (wr_commit) done_id_q <= wr_ptr;
      end
   end

   // Simple dual-port RAM with registered read data.
   always_ff @(posedge CLK) begin
      if (wr_store) mem[{wr_ptr, wr_beat[BA_W-1:0]}] <= bus.wr_data;
      if (rd_issue) ram_q <= mem[{rd_id_q, rd_cnt[BA_W-1:0]}];
   end

   // Read FSM state register.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) rd_state <= RD_IDLE;
      else        rd_state <= rd_next;
   end

   // Read FSM next state.
   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         RD_IDLE: if (rd_accept)     rd_next = RD_READ;
         RD_READ: if (rd_issue_last) rd_next = RD_IDLE;
         default: rd_next = RD_IDLE;
      endcase
   end

   // Read FSM outputs; requests are also blocked while the final beat is on the bus.
   always_comb begin
      rd_last_addr  = slot_len[rd_id_q] - BEAT_W'(1);
      rd_idle_ok    = (rd_state == RD_IDLE) & ~rd_valid_q;
      rd_accept     = rd_idle_ok & bus.rd_req &  slot_valid[bus.rd_id];
      rd_reject     = rd_idle_ok & bus.rd_req & ~slot_valid[bus.rd_id];
      rd_issue      = (rd_state == RD_READ);
      rd_issue_last = rd_issue & (rd_cnt == rd_last_addr);
      rd_release    = rd_valid_q & rd_last_q;
   end

   // Read address sequencer.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         rd_id_q <= '0;
         rd_cnt  <= '0;
      end else if (rd_accept) begin
         rd_id_q <= bus.rd_id;
         rd_cnt  <= '0;
      end else if (rd_issue) begin
         rd_cnt <= rd_cnt + BEAT_W'(1);
      end
   end

   // Beat qualifiers aligned with the one-cycle RAM read latency.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_keep_q  <= '0;
         rd_err_q   <= 1'b0;
      end else begin
         rd_valid_q <= rd_issue;
         rd_last_q  <= rd_issue_last;
         rd_keep_q  <= rd_issue ? (rd_issue_last ? slot_keep[rd_id_q] : '1) : '0;
         rd_err_q   <= rd_reject;
      end
   end

   // Output drive; RAM data is masked so idle/reset outputs read as zero.
   always_comb begin
      bus.wr_ready   = wr_ready_c;
      bus.wr_id      = wr_ptr;
      bus.wr_done    = done_q;
      bus.wr_done_id = done_id_q;
      bus.wr_ovf     = ovf_q;
      bus.rd_busy    = rd_issue | rd_valid_q;
      bus.rd_err     = rd_err_q;
      bus.rd_valid   = rd_valid_q;
      bus.rd_data    = rd_valid_q ? ram_q : '0;
      bus.rd_keep    = rd_keep_q;
      bus.rd_last    = rd_last_q;
      bus.occ_count  = occ_q;
   end
endmodule

// File: tb/tb_pkt_slot_buffer.sv
// Self-checking bench for pkt_slot_buffer (DATA_W=64, SLOTS=16, SLOT_BEATS=32).
module tb_pkt_slot_buffer;
   localparam int NS = 16;
   localparam int SB = 32;

   logic CLK = 1'b0;
   logic rst_n = 1'b1;
   bit   chk_en = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 CLK = ~CLK;

   pkt_slot_buffer_if #(.DATA_W(64), .SLOTS(NS)) bus ();

   pkt_slot_buffer #(.DATA_W(64), .SLOTS(NS), .SLOT_BEATS(SB)) dut (
      .CLK   (CLK),
      .reset (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Behavioural model: slot contents as queues, read schedule as cycle windows.
   int          cyc = 0;
   bit          m_valid [NS];
   logic [63:0] m_data  [NS][$];
   logic [7:0]  m_keep  [NS];
   int          m_wptr = 0;
   logic [63:0] m_cur [$];
   int          m_cnt = 0;
   bit          m_ovf = 0;
   bit          e_done = 0, e_ovf = 0, e_err = 0;
   int          e_done_id = 0;
   int          rd_p = -100, r_len = 0, r_slot = 0;
   logic [63:0] r_data [$];
   logic [7:0]  r_keep;

   always @(posedge CLK or negedge rst_n) begin : model
      bit rdy, busy_prev, req_ok, commit;
      int cslot;
      if (!rst_n) begin
         foreach (m_valid[i]) m_valid[i] = 1'b0;
         m_wptr = 0; m_cur.delete(); m_cnt = 0; m_ovf = 0;
         e_done = 0; e_ovf = 0; e_err = 0; r_len = 0; rd_p = -100;
         if (CLK) cyc++;
      end else begin
         cyc++;
         e_done = 0; e_ovf = 0; e_err = 0; req_ok = 0; commit = 0; cslot = 0;
         rdy = (m_cnt > 0) || !m_valid[m_wptr];
         busy_prev = (r_len > 0) && (cyc - 1 >= rd_p) && (cyc - 1 <= rd_p + r_len);
         if (bus.rd_req && !busy_prev) begin
            if (m_valid[bus.rd_id]) req_ok = 1; else e_err = 1;
         end
         if (bus.wr_valid && rdy) begin
            if (m_cur.size() < SB) m_cur.push_back(bus.wr_data); else m_ovf = 1;
            m_cnt++;
            if (bus.wr_last) begin
               commit = 1; cslot = m_wptr;
               m_data[cslot] = m_cur;
               m_keep[cslot] = m_ovf ? 8'hFF : bus.wr_keep;
               e_done = 1; e_done_id = cslot; e_ovf = m_ovf;
               m_wptr = (m_wptr + 1) % NS; m_cur.delete(); m_cnt = 0; m_ovf = 0;
            end
         end
         if ((r_len > 0) && (cyc == rd_p + r_len + 1)) m_valid[r_slot] = 1'b0;
         if (commit) m_valid[cslot] = 1'b1;
         if (req_ok) begin
            rd_p = cyc; r_slot = int'(bus.rd_id);
            r_data = m_data[r_slot]; r_keep = m_keep[r_slot]; r_len = r_data.size();
         end
      end
   end

   typedef struct {int cyc; logic [7:0] keep; logic last;} rd_ev_t;
   rd_ev_t rd_log [$];
   int err_cnt = 0;

   // Compare DUT against model every cycle, and log read beats / errors.
   always @(negedge CLK) begin : compare
      int k, occ;
      bit ev, eb, el;
      if (chk_en) begin
         occ = 0;
         foreach (m_valid[i]) occ += int'(m_valid[i]);
         eb = (r_len > 0) && (cyc >= rd_p) && (cyc <= rd_p + r_len);
         k  = cyc - rd_p - 1;
         ev = (r_len > 0) && (k >= 0) && (k < r_len);
         el = ev && (k == r_len - 1);
         chk("wr_ready",  64'(bus.wr_ready),  64'((m_cnt > 0) || !m_valid[m_wptr]));
         chk("wr_id",     64'(bus.wr_id),     64'(m_wptr));
         chk("wr_done",   64'(bus.wr_done),   64'(e_done));
         chk("wr_ovf",    64'(bus.wr_ovf),    64'(e_ovf));
         chk("rd_err",    64'(bus.rd_err),    64'(e_err));
         chk("rd_busy",   64'(bus.rd_busy),   64'(eb));
         chk("rd_valid",  64'(bus.rd_valid),  64'(ev));
         chk("rd_last",   64'(bus.rd_last),   64'(el));
         chk("occ_count", 64'(bus.occ_count), 64'(occ));
         if (e_done) chk("wr_done_id", 64'(bus.wr_done_id), 64'(e_done_id));
         if (ev) begin
            chk("rd_data", bus.rd_data, r_data[k]);
            chk("rd_keep", 64'(bus.rd_keep), 64'(el ? r_keep : 8'hFF));
         end
         if (bus.rd_valid) rd_log.push_back('{cyc, bus.rd_keep, bus.rd_last});
         if (bus.rd_err) err_cnt++;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      bus.wr_valid = 0; bus.wr_last = 0; bus.rd_req = 0;
      rst_n = 0;
      tick(); tick();
      rst_n = 1;
   endtask

   task automatic write_pkt(input int n, input logic [7:0] keep, input logic [63:0] base);
      for (int i = 0; i < n; i++) begin
         int guard = 0;
         bus.wr_valid = 1;
         bus.wr_data  = base + 64'(i);
         bus.wr_last  = (i == n - 1);
         bus.wr_keep  = (i == n - 1) ? keep : 8'h00;
         while (!bus.wr_ready && guard < 200) begin
            tick();
            guard++;
         end
         if (guard >= 200) begin
            chk("wr_ready_timeout", 64'(bus.wr_ready), 64'd1);
            bus.wr_valid = 0; bus.wr_last = 0;
            return;
         end
         tick();
      end
      bus.wr_valid = 0; bus.wr_last = 0;
   endtask

   task automatic read_req(input int id, output int t);
      bus.rd_req = 1; bus.rd_id = 4'(id); t = cyc;
      tick();
      bus.rd_req = 0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin : stim
      int t, e0, n0;
      bit all_ff;
      bus.wr_valid = 0; bus.wr_data = '0; bus.wr_keep = '0; bus.wr_last = 0;
      bus.rd_req = 0; bus.rd_id = '0;
      #2 rst_n = 0;
      #1 chk_en = 1;
      tick(); tick();
      rst_n = 1;
      chk("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
      chk("rst_occ",      64'(bus.occ_count), 64'd0);
      chk("rst_wr_id",    64'(bus.wr_id), 64'd0);
      chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);

      // 3-beat packet, keep 0x0F, then replay
      write_pkt(3, 8'h0F, 64'h1000);
      chk("t1_done",    64'(bus.wr_done), 64'd1);
      chk("t1_done_id", 64'(bus.wr_done_id), 64'd0);
      chk("t1_occ",     64'(bus.occ_count), 64'd1);
      rd_log.delete();
      read_req(0, t);
      repeat (6) tick();
      chk("t1_beats", 64'(rd_log.size()), 64'd3);
      if (rd_log.size() == 3) begin
         chk("t1_first_cyc", 64'(rd_log[0].cyc), 64'(t + 2));
         chk("t1_last_cyc",  64'(rd_log[2].cyc), 64'(t + 4));
         chk("t1_keep0", 64'(rd_log[0].keep), 64'hFF);
         chk("t1_keep1", 64'(rd_log[1].keep), 64'hFF);
         chk("t1_keep2", 64'(rd_log[2].keep), 64'h0F);
         chk("t1_last",  64'({rd_log[0].last, rd_log[1].last, rd_log[2].last}), 64'b001);
      end

      // fill all 16 slots, then free slot 0
      do_reset();
      for (int s = 0; s < NS; s++) write_pkt(2, 8'h03, 64'h2000 + 64'(s * 16));
      chk("t2_done_id", 64'(bus.wr_done_id), 64'd15);
      chk("t2_full",    64'(bus.wr_ready), 64'd0);
      chk("t2_occ",     64'(bus.occ_count), 64'd16);
      read_req(0, t);
      tick(); tick();
      chk("t2_ready_at_last", 64'(bus.wr_ready), 64'd0);
      tick();
      chk("t2_ready_after", 64'(bus.wr_ready), 64'd1);

      // 40-beat packet truncated to 32
      write_pkt(40, 8'h01, 64'h3000);
      chk("t3_done",    64'(bus.wr_done), 64'd1);
      chk("t3_ovf",     64'(bus.wr_ovf), 64'd1);
      chk("t3_done_id", 64'(bus.wr_done_id), 64'd0);
      rd_log.delete();
      read_req(0, t);
      repeat (36) tick();
      chk("t3_beats", 64'(rd_log.size()), 64'd32);
      all_ff = 1;
      foreach (rd_log[i]) if (rd_log[i].keep != 8'hFF) all_ff = 0;
      chk("t3_keep_ff", 64'(all_ff), 64'd1);
      if (rd_log.size() == 32) chk("t3_last", 64'(rd_log[31].last), 64'd1);

      // empty-slot error and requests during busy
      read_req(5, t);
      repeat (4) tick();
      e0 = err_cnt; n0 = rd_log.size();
      read_req(5, t);
      tick();
      chk("t4_err", 64'(err_cnt), 64'(e0 + 1));
      chk("t4_no_beats", 64'(rd_log.size()), 64'(n0));
      e0 = err_cnt;
      read_req(6, t);
      bus.rd_req = 1; bus.rd_id = 4'd5;
      tick();
      bus.rd_req = 0;
      tick();
      bus.rd_req = 1; bus.rd_id = 4'd7;
      tick();
      bus.rd_req = 0;
      repeat (4) tick();
      chk("t4_busy_no_err", 64'(err_cnt), 64'(e0));
      chk("t4_busy_beats",  64'(rd_log.size()), 64'(n0 + 2));

      // commit slot 2 on the same edge that releases slot 1
      do_reset();
      write_pkt(1, 8'hAA, 64'h5000);
      write_pkt(2, 8'h55, 64'h5100);
      read_req(1, t);
      tick(); tick();
      chk("t5_rd_last", 64'(bus.rd_last), 64'd1);
      chk("t5_occ_pre", 64'(bus.occ_count), 64'd2);
      bus.wr_valid = 1; bus.wr_last = 1; bus.wr_keep = 8'h3C; bus.wr_data = 64'h5200;
      tick();
      bus.wr_valid = 0; bus.wr_last = 0;
      chk("t5_occ_post", 64'(bus.occ_count), 64'd2);
      chk("t5_done_id",  64'(bus.wr_done_id), 64'd2);
      e0 = err_cnt;
      read_req(1, t);
      tick();
      chk("t5_slot1_empty", 64'(err_cnt), 64'(e0 + 1));
      rd_log.delete();
      read_req(2, t);
      repeat (4) tick();
      chk("t5_slot2_beats", 64'(rd_log.size()), 64'd1);
      if (rd_log.size() == 1) chk("t5_slot2_keep", 64'(rd_log[0].keep), 64'h3C);

      // asynchronous reset mid-write and mid-read
      bus.wr_valid = 1; bus.wr_last = 0; bus.wr_data = 64'h6000;
      tick();
      bus.wr_data = 64'h6001; bus.rd_req = 1; bus.rd_id = 4'd0;
      tick();
      bus.rd_req = 0;
      chk("t6_pre_busy", 64'(bus.rd_busy), 64'd1);
      #2 rst_n = 0; bus.wr_valid = 0;
      #1;
      chk("t6_wr_ready", 64'(bus.wr_ready), 64'd1);
      chk("t6_wr_id",    64'(bus.wr_id), 64'd0);
      chk("t6_rd_busy",  64'(bus.rd_busy), 64'd0);
      chk("t6_rd_valid", 64'(bus.rd_valid), 64'd0);
      chk("t6_rd_data",  bus.rd_data, 64'd0);
      chk("t6_rd_keep",  64'(bus.rd_keep), 64'd0);
      chk("t6_occ",      64'(bus.occ_count), 64'd0);
      chk("t6_wr_done",  64'(bus.wr_done), 64'd0);
      tick(); tick();
      rst_n = 1;
      e0 = err_cnt;
      read_req(0, t);
      tick();
      read_req(3, t);
      tick();
      chk("t6_old_ids_err", 64'(err_cnt), 64'(e0 + 2));
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
